mips_fetch_unit: RTL and testbench

Parametrised, decoupled instruction-fetch front end for the next-generation MIPS CPU. It replaces the single-cycle, fixed-latency instruction port with a variable-latency request/response memory interface and an N-entry prefetch queue. The queue presents (pc, instr) pairs to the decode stage through a valid/ready handshake. It also supports branch redirect with flush of in-flight responses, halt-on-jump-to-zero, and a global clk_enable stall.

---
 rtl/mips_fetch_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 61 ++++++
 rtl/mips_fetch_unit.sv | 117 +++++++++++
 tb/tb_mips_fetch_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the decoupled MIPS instruction-fetch front end.
// Queue entries carry a fetch PC together with the instruction word returned for it.
package mips_fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  localparam logic [FETCH_ADDR_W-1:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [FETCH_ADDR_W-1:0] HALT_ADDR            = '0;

  // FS_HALTING waits for dropped responses to drain before active falls.
  typedef enum logic [1:0] {
    FS_RUN     = 2'd0,
    FS_HALTING = 2'd1,
    FS_HALTED  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Ring-buffer prefetch queue: a slot is reserved with its PC at issue time and
// completed with the instruction word when the in-order response arrives.
module fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = count_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    reserve,
  input  logic [FETCH_ADDR_W-1:0] reserve_pc,
  input  logic                    fill,
  input  logic [FETCH_DATA_W-1:0] fill_instr,
  input  logic                    pop,
  input  logic                    flush,
  output logic                    head_valid,
  output fetch_entry_t            head,
  output logic [CW-1:0]           count
);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  fill_ptr;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fill_ptr <= '0;
      count    <= '0;
    end else if (en) begin
      if (flush) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fill_ptr <= '0;
        count    <= '0;
      end else begin
        if (reserve) wr_ptr   <= wr_ptr + PW'(1);
        if (fill)    fill_ptr <= fill_ptr + PW'(1);
        if (pop)     rd_ptr   <= rd_ptr + PW'(1);
        count <= count + CW'(fill) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && !flush) begin
      if (reserve) mem[wr_ptr].pc      <= reserve_pc;
      if (fill)    mem[fill_ptr].instr <= fill_instr;
    end
  end

  assign head_valid = (count != '0);
  assign head       = mem[rd_ptr];

endmodule

// File: rtl/mips_fetch_unit.sv
// Decoupled instruction fetch: PC, credit-limited issue to a variable-latency memory,
// drop counting for responses orphaned by a redirect, and halt on jump to address 0.
//
// Handshakes: a memory request transfers on a rising edge where instr_read=1 and
// instr_waitrequest=0, and instr_read/instr_address hold while stalled; a queue entry
// transfers to decode on an edge where out_valid=1, out_ready=1 and clk_enable=1.
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int               ADDR_W       = 32,
  parameter int               DATA_W       = 32,
  parameter int               DEPTH        = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  output logic              active,
  output logic [ADDR_W-1:0] instr_address,
  output logic              instr_read,
  input  logic              instr_waitrequest,
  input  logic [DATA_W-1:0] instr_readdata,
  input  logic              instr_readdatavalid,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr
);

  localparam int CW = count_width(DEPTH);
  localparam int SW = CW + 2;

  typedef logic [CW-1:0] cnt_t;

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  cnt_t              outstanding;
  cnt_t              drop;
  cnt_t              count;
  logic [SW-1:0]     in_flight;
  logic              has_credit;
  logic              accept;
  logic              resp_drop;
  logic              resp_fill;
  logic              take_redirect;
  logic              pop;
  cnt_t              drop_after_resp;
  cnt_t              drop_on_redirect;
  fetch_entry_t      head;
  logic              head_valid;

  // Orphaned reads still occupy slots they will never fill, so drop counts against
  // the credit too; this caps every counter at DEPTH across back-to-back redirects.
  assign in_flight  = SW'(count) + SW'(outstanding) + SW'(drop);
  assign has_credit = (in_flight < SW'(DEPTH));

  assign instr_read    = !reset && clk_enable && (state == FS_RUN) && !redirect && has_credit;
  assign instr_address = pc;
  assign accept        = instr_read && !instr_waitrequest;

  assign resp_drop     = clk_enable && instr_readdatavalid && (drop != '0);
  assign resp_fill     = clk_enable && instr_readdatavalid && (drop == '0);
  assign take_redirect = clk_enable && redirect && (state == FS_RUN);
  assign pop           = head_valid && out_ready && clk_enable;

  assign drop_after_resp  = drop - cnt_t'(resp_drop);
  assign drop_on_redirect = drop + outstanding - cnt_t'(instr_readdatavalid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FS_RUN;
      pc          <= RESET_VECTOR;
      outstanding <= '0;
      drop        <= '0;
    end else if (clk_enable) begin
      if (take_redirect) begin
        pc          <= redirect_target;
        outstanding <= '0;
        drop        <= drop_on_redirect;
        if (redirect_target == ADDR_W'(HALT_ADDR))
          state <= (drop_on_redirect == '0) ? FS_HALTED : FS_HALTING;
      end else begin
        if (accept) pc <= pc + ADDR_W'(4);
        outstanding <= outstanding + cnt_t'(accept) - cnt_t'(resp_fill);
        drop        <= drop_after_resp;
        if ((state == FS_HALTING) && (drop_after_resp == '0))
          state <= FS_HALTED;
      end
    end
  end

  assign active = (state != FS_HALTED);

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (reset),
    .en         (clk_enable),
    .reserve    (accept),
    .reserve_pc (FETCH_ADDR_W'(pc)),
    .fill       (resp_fill),
    .fill_instr (FETCH_DATA_W'(instr_readdata)),
    .pop        (pop),
    .flush      (take_redirect),
    .head_valid (head_valid),
    .head       (head),
    .count      (count)
  );

  assign out_valid = head_valid;
  assign out_pc    = ADDR_W'(head.pc);
  assign out_instr = DATA_W'(head.instr);

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: cycle table for streaming/backpressure plus directed
// sequences for wait states, redirect drop, halt, reset mid-burst and clk_enable stall.
`timescale 1ns/1ps
module tb_mips_fetch_unit;
  import mips_fetch_pkg::*;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RV     = 32'hBFC0_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic              clk_enable;
  logic              active;
  logic [ADDR_W-1:0] instr_address;
  logic              instr_read;
  logic              instr_waitrequest;
  logic [DATA_W-1:0] instr_readdata;
  logic              instr_readdatavalid;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_instr;

  mips_fetch_unit #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .RESET_VECTOR (RV)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .clk_enable          (clk_enable),
    .active              (active),
    .instr_address       (instr_address),
    .instr_read          (instr_read),
    .instr_waitrequest   (instr_waitrequest),
    .instr_readdata      (instr_readdata),
    .instr_readdatavalid (instr_readdatavalid),
    .redirect            (redirect),
    .redirect_target     (redirect_target),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_pc              (out_pc),
    .out_instr           (out_instr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // memory model and scoreboard state
  int          cyc;
  int          mem_lat;
  int          wait_left;
  int          accepted;
  int          pops;
  logic        sb_on;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_q[$];

  typedef struct {
    logic        restart;
    logic        rdy;
    logic        exp_read;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[17];
  int   nv;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, a[31:16]};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset               = 1'b1;
    clk_enable          = 1'b1;
    redirect            = 1'b0;
    redirect_target     = '0;
    out_ready           = 1'b0;
    instr_waitrequest   = 1'b0;
    instr_readdatavalid = 1'b0;
    instr_readdata      = '0;
    pend_addr.delete();
    pend_due.delete();
    exp_q.delete();
    wait_left = 0;
    mem_lat   = 1;
    sb_on     = 1'b0;
    accepted  = 0;
    pops      = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive memory outputs for this cycle and let them settle.
  task automatic cycle_begin();
    logic [31:0] a;
    int          d;
    instr_waitrequest = (wait_left > 0);
    if (clk_enable && !reset && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      a = pend_addr.pop_front();
      d = pend_due.pop_front();
      instr_readdatavalid = 1'b1;
      instr_readdata      = instr_of(a);
    end else begin
      instr_readdatavalid = 1'b0;
      instr_readdata      = '0;
    end
    #1;
  endtask

  // Records the accepted request and any pop, then advances to the next falling edge.
  task automatic cycle_end();
    logic [31:0] e;
    if (!reset && instr_read && !instr_waitrequest) begin
      pend_addr.push_back(instr_address);
      pend_due.push_back(cyc + mem_lat);
      accepted++;
    end
    if (sb_on && clk_enable && !reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got pc %h expected no entry", out_pc);
      end else begin
        e = exp_q.pop_front();
        check32("sb_pc", out_pc, e);
        check32("sb_instr", out_instr, instr_of(e));
        pops++;
      end
    end
    if (clk_enable && wait_left > 0) wait_left--;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic add_vec(input logic restart, input logic rdy, input logic rd,
                         input logic [31:0] addr_off, input logic v, input logic [31:0] pc_off);
    vecs[nv].restart   = restart;
    vecs[nv].rdy       = rdy;
    vecs[nv].exp_read  = rd;
    vecs[nv].exp_addr  = RV + addr_off;
    vecs[nv].exp_valid = v;
    vecs[nv].exp_pc    = RV + pc_off;
    nv++;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    // streaming with zero-wait memory, then DEPTH-limited backpressure
    nv = 0;
    add_vec(1, 1, 1, 32'h00, 0, 32'h00);
    add_vec(0, 1, 1, 32'h04, 0, 32'h00);
    add_vec(0, 1, 1, 32'h08, 1, 32'h00);
    add_vec(0, 1, 1, 32'h0C, 1, 32'h04);
    add_vec(0, 1, 1, 32'h10, 1, 32'h08);
    add_vec(0, 1, 1, 32'h14, 1, 32'h0C);
    add_vec(1, 0, 1, 32'h00, 0, 32'h00);
    add_vec(0, 0, 1, 32'h04, 0, 32'h00);
    add_vec(0, 0, 1, 32'h08, 1, 32'h00);
    add_vec(0, 0, 1, 32'h0C, 1, 32'h00);
    add_vec(0, 0, 0, 32'h00, 1, 32'h00);
    add_vec(0, 0, 0, 32'h00, 1, 32'h00);
    add_vec(0, 1, 0, 32'h00, 1, 32'h00);
    add_vec(0, 1, 1, 32'h10, 1, 32'h04);
    add_vec(0, 1, 1, 32'h14, 1, 32'h08);
    add_vec(0, 1, 1, 32'h18, 1, 32'h0C);
    add_vec(0, 1, 1, 32'h1C, 1, 32'h10);

    // reset values
    reset = 1'b1; clk_enable = 1'b1; redirect = 1'b0; redirect_target = '0;
    out_ready = 1'b0; instr_waitrequest = 1'b0; instr_readdatavalid = 1'b0; instr_readdata = '0;
    @(negedge clk); #1;
    check1("rst_active", active, 1'b1);
    check1("rst_read", instr_read, 1'b0);
    check32("rst_addr", instr_address, RV);
    check1("rst_valid", out_valid, 1'b0);

    for (int i = 0; i < nv; i++) begin
      if (vecs[i].restart) do_reset();
      out_ready = vecs[i].rdy;
      cycle_begin();
      check1($sformatf("v%0d_read", i), instr_read, vecs[i].exp_read);
      if (vecs[i].exp_read) check32($sformatf("v%0d_addr", i), instr_address, vecs[i].exp_addr);
      check1($sformatf("v%0d_valid", i), out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check32($sformatf("v%0d_pc", i), out_pc, vecs[i].exp_pc);
        check32($sformatf("v%0d_instr", i), out_instr, instr_of(vecs[i].exp_pc));
      end
      cycle_end();
    end

    // waitrequest held for 3 cycles
    do_reset();
    out_ready = 1'b1;
    wait_left = 3;
    for (int k = 0; k < 3; k++) begin
      cycle_begin();
      check1("wait_read", instr_read, 1'b1);
      check32("wait_addr", instr_address, RV);
      cycle_end();
    end
    check32("wait_none_accepted", accepted, 0);
    cycle_begin();
    check32("wait_release_addr", instr_address, RV);
    cycle_end();
    check32("wait_one_accepted", accepted, 1);
    cycle_begin();
    check32("wait_next_addr", instr_address, RV + 32'h4);
    cycle_end();

    // redirect with two reads outstanding, 3-cycle latency
    do_reset();
    mem_lat = 3; out_ready = 1'b1; sb_on = 1'b1;
    cycle_begin(); cycle_end();
    cycle_begin(); cycle_end();
    check32("redir_outstanding", accepted, 2);
    redirect = 1'b1; redirect_target = 32'h0040_0000;
    cycle_begin();
    check1("redir_read_gated", instr_read, 1'b0);
    cycle_end();
    redirect = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back(32'h0040_0000 + 32'(4 * k));
    pops = 0;
    cycle_begin();
    check32("redir_new_addr", instr_address, 32'h0040_0000);
    cycle_end();
    for (int k = 0; k < 9; k++) begin
      cycle_begin(); cycle_end();
    end
    check1("redir_pops", pops >= 4, 1'b1);
    sb_on = 1'b0;

    // halt: redirect to 0 with one read outstanding
    do_reset();
    mem_lat = 3; out_ready = 1'b1;
    cycle_begin(); cycle_end();
    redirect = 1'b1; redirect_target = '0;
    cycle_begin();
    check1("halt_read_gated", instr_read, 1'b0);
    cycle_end();
    redirect = 1'b0;
    cycle_begin();
    check1("halt_active_c2", active, 1'b1);
    check1("halt_read_c2", instr_read, 1'b0);
    cycle_end();
    cycle_begin();
    check1("halt_active_c3", active, 1'b1);
    cycle_end();
    for (int k = 4; k < 10; k++) begin
      redirect = (k == 5);
      redirect_target = 32'h0000_1000;
      cycle_begin();
      check1($sformatf("halt_active_c%0d", k), active, 1'b0);
      check1($sformatf("halt_read_c%0d", k), instr_read, 1'b0);
      check1($sformatf("halt_valid_c%0d", k), out_valid, 1'b0);
      cycle_end();
    end
    redirect = 1'b0;
    check32("halt_accepted", accepted, 1);

    // reset mid-burst, restart, then a clk_enable stall
    do_reset();
    out_ready = 1'b1; sb_on = 1'b1;
    for (int k = 0; k < 16; k++) exp_q.push_back(RV + 32'(4 * k));
    for (int k = 0; k < 5; k++) begin
      cycle_begin(); cycle_end();
    end
    cycle_begin();
    reset = 1'b1;
    #1;
    check1("midrst_read", instr_read, 1'b0);
    check32("midrst_addr", instr_address, RV);
    check1("midrst_valid", out_valid, 1'b0);
    check1("midrst_active", active, 1'b1);
    do_reset();
    out_ready = 1'b1; sb_on = 1'b1;
    for (int k = 0; k < 16; k++) exp_q.push_back(RV + 32'(4 * k));
    cycle_begin();
    check32("restart_addr", instr_address, RV);
    cycle_end();
    for (int k = 1; k < 5; k++) begin
      cycle_begin(); cycle_end();
    end
    clk_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle_begin();
      check1("stall_read", instr_read, 1'b0);
      check1("stall_valid", out_valid, 1'b1);
      check32("stall_pc", out_pc, RV + 32'h0C);
      cycle_end();
    end
    clk_enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle_begin(); cycle_end();
    end
    check1("stall_pops", pops >= 5, 1'b1);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
